// File: rtl/xdma_from_remote_cfg_deframer_pkg.sv
// Shared types for the inter-cluster configuration deframer: frame layouts,
// reassembled header and the deframer state encoding.
package xdma_from_remote_cfg_deframer_pkg;

  localparam int unsigned FrameWidth       = 512;
  localparam int unsigned FrameLengthWidth = 4;
  localparam int unsigned DmaIdWidth       = 8;
  localparam int unsigned AddrWidth        = 64;
  localparam int unsigned HeaderWidth      = 1 + FrameLengthWidth + DmaIdWidth + 2 * AddrWidth;

  localparam int unsigned FirstFrameRemaingPayloadWidth = FrameWidth - HeaderWidth;
  localparam int unsigned RemainingPayloadWidth         = FrameWidth - 1 - FrameLengthWidth;

  typedef logic [FrameWidth-1:0]                    xdma_from_remote_data_t;
  typedef logic [FrameLengthWidth-1:0]              frame_length_t;
  typedef logic [DmaIdWidth-1:0]                    dma_id_t;
  typedef logic [AddrWidth-1:0]                     addr_t;
  typedef logic [FirstFrameRemaingPayloadWidth-1:0] first_frame_remaining_payload_t;
  typedef logic [RemainingPayloadWidth-1:0]         remaining_payload_t;

  // First frame: header in the LSBs, first payload slice above it.
  typedef struct packed {
    first_frame_remaining_payload_t remaining_payload;
    addr_t                          writer_addr;
    addr_t                          reader_addr;
    dma_id_t                        dma_id;
    frame_length_t                  frame_length;
    logic                           dma_type;
  } xdma_inter_cluster_cfg_t;

  typedef struct packed {
    remaining_payload_t remaining_payload;
    frame_length_t      frame_idx;
    logic               dma_type;
  } xdma_inter_cluster_cont_t;

  typedef struct packed {
    addr_t         writer_addr;
    addr_t         reader_addr;
    dma_id_t       dma_id;
    frame_length_t frame_length;
    logic          dma_type;
  } xdma_cfg_header_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } xdma_deframer_state_e;

endpackage

// File: rtl/xdma_from_remote_cfg_deframer.sv
// Reassembles a multi-frame inter-cluster configuration from 512-bit beats and
// hands it to the local XDMA controller over a valid/ready handshake.
module xdma_from_remote_cfg_deframer
  import xdma_from_remote_cfg_deframer_pkg::*;
#(
  parameter int unsigned  MaxFrames    = 4,
  localparam int unsigned PayloadWidth = FirstFrameRemaingPayloadWidth
                                         + (MaxFrames - 1) * RemainingPayloadWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  xdma_from_remote_data_t  frame_i,
  input  logic                    frame_valid_i,
  output logic                    frame_ready_o,
  output xdma_cfg_header_t        cfg_hdr_o,
  output logic [PayloadWidth-1:0] cfg_payload_o,
  output logic                    cfg_valid_o,
  input  logic                    cfg_ready_i,
  output logic                    err_o
);

  localparam int unsigned   FirstW       = FirstFrameRemaingPayloadWidth;
  localparam int unsigned   RemW         = RemainingPayloadWidth;
  localparam frame_length_t MaxFramesLen = frame_length_t'(MaxFrames);

  xdma_deframer_state_e     state_q, state_d;
  xdma_cfg_header_t         hdr_q, hdr_d;
  logic [PayloadWidth-1:0]  payload_q, payload_d;
  frame_length_t            idx_q, idx_d;
  logic                     err_q, err_d;
  logic                     frame_ready_q, frame_ready_d;
  logic                     cfg_valid_q, cfg_valid_d;

  xdma_inter_cluster_cfg_t  first_frame;
  xdma_inter_cluster_cont_t cont_frame;
  logic                     frame_hs;
  logic                     cont_match;
  logic                     last_idx;

  assign first_frame = frame_i;
  assign cont_frame  = frame_i;
  assign frame_hs    = frame_valid_i & frame_ready_q;
  assign cont_match  = (cont_frame.frame_idx == idx_q) && (cont_frame.dma_type == hdr_q.dma_type);
  // idx_q counts stored/skipped frames; the last one is frame_length-1.
  assign last_idx    = (idx_q == frame_length_t'(hdr_q.frame_length - frame_length_t'(1)));

  // Next-state, header/payload capture and error pulse generation.
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_hs) begin
          hdr_d = '{writer_addr:  first_frame.writer_addr,
                    reader_addr:  first_frame.reader_addr,
                    dma_id:       first_frame.dma_id,
                    frame_length: first_frame.frame_length,
                    dma_type:     first_frame.dma_type};
          payload_d             = '0;
          payload_d[FirstW-1:0] = first_frame.remaining_payload;
          idx_d                 = frame_length_t'(1);
          if (first_frame.frame_length == '0) begin
            err_d = 1'b1;
          end else if (first_frame.frame_length == frame_length_t'(1)) begin
            state_d = OUTPUT;
          end else if (first_frame.frame_length <= MaxFramesLen) begin
            state_d = COLLECT;
          end else begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (frame_hs) begin
          if (cont_match) begin
            for (int unsigned k = 1; k < MaxFrames; k++) begin
              if (idx_q == frame_length_t'(k)) begin
                payload_d[FirstW + (k - 1) * RemW +: RemW] = cont_frame.remaining_payload;
              end
            end
            idx_d = frame_length_t'(idx_q + frame_length_t'(1));
            if (last_idx) state_d = OUTPUT;
          end else begin
            // Drop the partial configuration; the next beat resynchronises.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (frame_hs) begin
          idx_d = frame_length_t'(idx_q + frame_length_t'(1));
          if (last_idx) state_d = IDLE;
        end
      end

      OUTPUT: begin
        if (cfg_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    frame_ready_d = (state_d != OUTPUT);
    cfg_valid_d   = (state_d == OUTPUT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      hdr_q         <= '0;
      payload_q     <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      frame_ready_q <= 1'b0;
      cfg_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      payload_q     <= payload_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      frame_ready_q <= frame_ready_d;
      cfg_valid_q   <= cfg_valid_d;
    end
  end

  assign frame_ready_o = frame_ready_q;
  assign cfg_hdr_o     = hdr_q;
  assign cfg_payload_o = payload_q;
  assign cfg_valid_o   = cfg_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_xdma_from_remote_cfg_deframer.sv
// Self-checking bench for the configuration deframer: directed vector table,
// hand-written timing sequences and randomized streams against a stream-parsing model.
module tb_xdma_from_remote_cfg_deframer;
  import xdma_from_remote_cfg_deframer_pkg::*;

  localparam int unsigned MAX = 4;
  localparam int unsigned FW  = FirstFrameRemaingPayloadWidth;
  localparam int unsigned RW  = RemainingPayloadWidth;
  localparam int unsigned PW  = FW + (MAX - 1) * RW;

  typedef logic [511:0] beat_t;
  typedef struct { xdma_cfg_header_t hdr; logic [PW-1:0] pay; } cfg_t;
  typedef struct {
    int len; int bad_pos; bit bad_type; int gap;
    logic [7:0] id; logic [63:0] ra; logic [63:0] wa;
    int exp_cfgs; int exp_errs;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  beat_t            frame_i;
  logic             frame_valid_i;
  logic             frame_ready_o;
  xdma_cfg_header_t cfg_hdr_o;
  logic [PW-1:0]    cfg_payload_o;
  logic             cfg_valid_o;
  logic             cfg_ready_i;
  logic             err_o;

  xdma_from_remote_cfg_deframer #(.MaxFrames(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
    .frame_ready_o(frame_ready_o), .cfg_hdr_o(cfg_hdr_o), .cfg_payload_o(cfg_payload_o),
    .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int               n_chk = 0;
  int               n_fail = 0;
  int               err_seen = 0;
  int               ready_prob = 100;
  int               cyc = 0;
  int               exp_errs = 0;
  beat_t            stim_q[$];
  cfg_t             got_q[$];
  cfg_t             exp_q[$];
  xdma_cfg_header_t snap_hdr;
  logic [PW-1:0]    snap_pay;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [2047:0] got, input logic [2047:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: wide values differ, low 64 bits got 0x%0h, expected 0x%0h",
               name, got[63:0], exp[63:0]);
    end
  endtask

  function automatic beat_t rnd512();
    beat_t r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: decide cfg_ready, record the consumer handshake, advance, count err pulses.
  task automatic step();
    cfg_t c;
    logic hold;
    cfg_ready_i = ($urandom_range(0, 99) < ready_prob);
    hold = cfg_valid_o && !cfg_ready_i && rst_n;
    if (cfg_valid_o && cfg_ready_i && rst_n) begin
      c.hdr = cfg_hdr_o;
      c.pay = cfg_payload_o;
      got_q.push_back(c);
    end
    if (hold) begin
      snap_hdr = cfg_hdr_o;
      snap_pay = cfg_payload_o;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (err_o) err_seen++;
    if (hold) begin
      n_chk++;
      if (!cfg_valid_o || cfg_hdr_o !== snap_hdr || cfg_payload_o !== snap_pay) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%0b hdr_id=0x%0h (expected valid=1 hdr_id=0x%0h, unchanged)",
                 cfg_valid_o, cfg_hdr_o.dma_id, snap_hdr.dma_id);
      end
    end
  endtask

  task automatic drive_beat(input beat_t b);
    logic hs;
    frame_valid_i = 1'b1;
    frame_i = b;
    for (int t = 0; t < 64; t++) begin
      hs = frame_ready_o && rst_n;
      step();
      if (hs) begin
        stim_q.push_back(b);
        frame_valid_i = 1'b0;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL beat_timeout: frame_ready_o stayed %0b, expected 1 within 64 cycles", frame_ready_o);
    frame_valid_i = 1'b0;
  endtask

  task automatic send_cfg(input logic t, input int len, input logic [7:0] id,
                          input logic [63:0] ra, input logic [63:0] wa,
                          input int bad_pos, input bit bad_type, input int gap);
    beat_t b;
    b = rnd512();
    b[0] = t; b[4:1] = 4'(len); b[12:5] = id; b[76:13] = ra; b[140:77] = wa;
    drive_beat(b);
    for (int k = 1; k < len; k++) begin
      repeat (gap) step();
      b = rnd512();
      b[0]   = (k == bad_pos && bad_type) ? ~t : t;
      b[4:1] = (k == bad_pos && !bad_type) ? 4'(k + 1) : 4'(k);
      drive_beat(b);
    end
  endtask

  // Reference: parse the accepted beat stream by the framing rules.
  task automatic model_run();
    int i = 0;
    int n = stim_q.size();
    exp_q.delete();
    exp_errs = 0;
    while (i < n) begin
      beat_t b;
      cfg_t  c;
      int    len;
      bit    ok;
      b = stim_q[i];
      i++;
      len = int'(b[4:1]);
      if (len == 0) begin exp_errs++; continue; end
      if (len > int'(MAX)) begin exp_errs++; i += len - 1; continue; end
      c.hdr.dma_type = b[0];
      c.hdr.frame_length = b[4:1];
      c.hdr.dma_id = b[12:5];
      c.hdr.reader_addr = b[76:13];
      c.hdr.writer_addr = b[140:77];
      c.pay = '0;
      c.pay[FW-1:0] = b[511:141];
      ok = 1'b1;
      for (int k = 1; k < len; k++) begin
        beat_t cb;
        if (i >= n) begin ok = 1'b0; break; end
        cb = stim_q[i];
        i++;
        if (int'(cb[4:1]) != k || cb[0] != b[0]) begin exp_errs++; ok = 1'b0; break; end
        c.pay[FW + (k - 1) * RW +: RW] = cb[511:5];
      end
      if (ok) exp_q.push_back(c);
    end
  endtask

  task automatic begin_seg();
    stim_q.delete();
    got_q.delete();
    err_seen = 0;
  endtask

  task automatic end_seg(input string name, input int tab_cfgs, input int tab_errs);
    int m;
    ready_prob = 100;
    for (int t = 0; t < 20 && (cfg_valid_o || !frame_ready_o); t++) step();
    step();
    model_run();
    chk({name, "_cfg_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({name, "_err_count"}, 64'(err_seen), 64'(exp_errs));
    if (tab_cfgs >= 0) begin
      chk({name, "_tab_cfgs"}, 64'(got_q.size()), 64'(tab_cfgs));
      chk({name, "_tab_errs"}, 64'(err_seen), 64'(tab_errs));
    end
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int j = 0; j < m; j++) begin
      chk_w($sformatf("%s_hdr%0d", name, j), 2048'(got_q[j].hdr), 2048'(exp_q[j].hdr));
      chk_w($sformatf("%s_pay%0d", name, j), 2048'(got_q[j].pay), 2048'(exp_q[j].pay));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs[8];
    beat_t b;
    int    c0;

    vecs[0] = '{len:1,  bad_pos:0, bad_type:0, gap:0, id:8'd3,    ra:64'h1000, wa:64'h2000, exp_cfgs:1, exp_errs:0};
    vecs[1] = '{len:3,  bad_pos:0, bad_type:0, gap:1, id:8'h11,   ra:64'hA0,   wa:64'hB0,   exp_cfgs:1, exp_errs:0};
    vecs[2] = '{len:4,  bad_pos:0, bad_type:0, gap:0, id:8'h22,   ra:64'h1,    wa:64'h2,    exp_cfgs:1, exp_errs:0};
    vecs[3] = '{len:2,  bad_pos:1, bad_type:0, gap:0, id:8'h33,   ra:64'h5,    wa:64'h6,    exp_cfgs:0, exp_errs:1};
    vecs[4] = '{len:3,  bad_pos:2, bad_type:1, gap:1, id:8'h44,   ra:64'h7,    wa:64'h8,    exp_cfgs:0, exp_errs:1};
    vecs[5] = '{len:0,  bad_pos:0, bad_type:0, gap:0, id:8'h55,   ra:64'h9,    wa:64'hA,    exp_cfgs:0, exp_errs:1};
    vecs[6] = '{len:6,  bad_pos:0, bad_type:0, gap:0, id:8'h66,   ra:64'hB,    wa:64'hC,    exp_cfgs:0, exp_errs:1};
    vecs[7] = '{len:15, bad_pos:0, bad_type:0, gap:1, id:8'h77,   ra:64'hD,    wa:64'hE,    exp_cfgs:0, exp_errs:1};

    frame_valid_i = 1'b0;
    frame_i = '0;
    cfg_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();

    chk("rst_frame_ready", 64'(frame_ready_o), 64'(0));
    chk("rst_cfg_valid", 64'(cfg_valid_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk_w("rst_hdr", 2048'(cfg_hdr_o), 2048'(0));
    chk_w("rst_payload", 2048'(cfg_payload_o), 2048'(0));
    rst_n = 1'b1;
    step();
    chk("post_rst_frame_ready", 64'(frame_ready_o), 64'(1));

    // Single frame: valid in the cycle after the handshake, empty upper slots.
    begin_seg();
    b = rnd512();
    b[0] = 1'b0; b[4:1] = 4'd1; b[12:5] = 8'd3; b[76:13] = 64'h1000; b[140:77] = 64'h2000;
    drive_beat(b);
    chk("single_valid_latency", 64'(cfg_valid_o), 64'(1));
    chk("single_id", 64'(cfg_hdr_o.dma_id), 64'(3));
    chk("single_raddr", 64'(cfg_hdr_o.reader_addr), 64'h1000);
    chk("single_waddr", 64'(cfg_hdr_o.writer_addr), 64'h2000);
    chk_w("single_upper_zero", 2048'(cfg_payload_o[PW-1:FW]), 2048'(0));
    step();
    chk("single_ready_after", 64'(frame_ready_o), 64'(1));
    chk("single_valid_after", 64'(cfg_valid_o), 64'(0));
    end_seg("single", 1, 0);

    // Consumer stall for 5 cycles, then back-to-back first frame.
    begin_seg();
    ready_prob = 0;
    send_cfg(1'b1, 2, 8'h9, 64'h30, 64'h40, 0, 1'b0, 0);
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("stall_frame_ready%0d", t), 64'(frame_ready_o), 64'(0));
      chk($sformatf("stall_valid%0d", t), 64'(cfg_valid_o), 64'(1));
      step();
    end
    ready_prob = 100;
    step();
    chk("b2b_frame_ready", 64'(frame_ready_o), 64'(1));
    c0 = cyc;
    send_cfg(1'b0, 1, 8'hA, 64'h50, 64'h60, 0, 1'b0, 0);
    chk("b2b_accept_cycles", 64'(cyc - c0), 64'(1));
    end_seg("stall", 2, 0);

    // Bad idx: one-cycle err pulse, next beat parsed as a first frame.
    begin_seg();
    b = rnd512(); b[0] = 1'b0; b[4:1] = 4'd2;
    drive_beat(b);
    b = rnd512(); b[0] = 1'b0; b[4:1] = 4'd2;
    drive_beat(b);
    chk("badidx_err_high", 64'(err_o), 64'(1));
    step();
    chk("badidx_err_low", 64'(err_o), 64'(0));
    chk("badidx_no_valid", 64'(cfg_valid_o), 64'(0));
    send_cfg(1'b1, 1, 8'hC, 64'h70, 64'h80, 0, 1'b0, 0);
    end_seg("badidx", 1, 1);

    foreach (vecs[i]) begin
      begin_seg();
      send_cfg(1'($urandom_range(0, 1)), vecs[i].len, vecs[i].id, vecs[i].ra, vecs[i].wa,
               vecs[i].bad_pos, vecs[i].bad_type, vecs[i].gap);
      end_seg($sformatf("vec%0d", i), vecs[i].exp_cfgs, vecs[i].exp_errs);
    end

    // Randomized stream, judged only by the parsing model.
    begin_seg();
    for (int r = 0; r < 60; r++) begin
      int len;
      int bad;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
      bad = ($urandom_range(0, 4) == 0 && len > 1) ? $urandom_range(1, len - 1) : 0;
      ready_prob = $urandom_range(20, 100);
      send_cfg(1'($urandom_range(0, 1)), len, 8'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, bad, bit'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    end_seg("random", -1, -1);

    // Reset mid-collect discards the partial configuration.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    begin_seg();
    b = rnd512(); b[0] = 1'b0; b[4:1] = 4'd4;
    drive_beat(b);
    b = rnd512(); b[0] = 1'b0; b[4:1] = 4'd1;
    drive_beat(b);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 64'(cfg_valid_o), 64'(0));
    chk("midrst_frame_ready", 64'(frame_ready_o), 64'(0));
    chk_w("midrst_payload", 2048'(cfg_payload_o), 2048'(0));
    rst_n = 1'b1;
    step();
    begin_seg();
    send_cfg(1'b1, 1, 8'hEE, 64'h123, 64'h456, 0, 1'b0, 0);
    end_seg("midrst", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xdma_from_remote_cfg_deframer.md
# xdma_from_remote_cfg_deframer

Receive-side counterpart of the inter-cluster configuration framer. Consumes the 512-bit beats routed to the `FromRemoteCfg` output of the address decoder and validates the first-frame header and continuation frames. Reassembles up to `MaxFrames` frames into one configuration and presents it, with a valid/ready handshake, to the local XDMA controller.

## Interface
Parameters:
- `MaxFrames`, default 4: largest accepted frame count; legal range 1..15.
- `PayloadWidth`, default `FirstFrameRemaingPayloadWidth + (MaxFrames-1)*RemainingPayloadWidth`: width of the reassembled payload, derived and not overridden.

Ports:
- `clk_i`, in, 1: the only clock.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `frame_i`, in, 512 (`xdma_from_remote_data_t`): incoming frame beat.
- `frame_valid_i`, in, 1: `frame_i` is valid.
- `frame_ready_o`, out, 1: deframer accepts the beat this cycle.
- `cfg_hdr_o`, out, `xdma_cfg_header_t`: `dma_type`, `frame_length`, `dma_id`, `reader_addr`, `writer_addr`.
- `cfg_payload_o`, out, `PayloadWidth`: first-frame payload in the LSBs, then continuation payloads in arrival order.
- `cfg_valid_o`, out, 1: a complete configuration is presented.
- `cfg_ready_i`, in, 1: the consumer takes the configuration.
- `err_o`, out, 1: one-cycle pulse on a protocol error.

## Operation
- First frame uses the layout `xdma_inter_cluster_cfg_t`. `frame_length` = total frames, including the first.
- Continuation frame uses the layout `xdma_inter_cluster_cont_t`:
  - bit 0: `dma_type`, must equal the header value.
  - bits [4:1]: `frame_idx`; the k-th continuation frame carries idx k (1..N-1).
  - bits [511:5]: payload.
- FSM states:
  - IDLE: `frame_ready_o`=1.
    - On a first-frame handshake: latch header, write the first payload to slot 0, zero all other payload slots, set `idx_q`=1.
    - `frame_length`==1 → OUTPUT.
    - `frame_length` in 2..`MaxFrames` → COLLECT.
    - `frame_length`==0 → pulse `err_o` and stay in IDLE (frame dropped).
    - `frame_length`>`MaxFrames` → DRAIN; pulse `err_o` when entering DRAIN.
  - COLLECT: `frame_ready_o`=1.
    - On a handshake with a matching idx and `dma_type`: store the payload in slot `idx_q` and increment `idx_q`. When `idx_q`==`frame_length`-1 was just stored → OUTPUT.
    - On a mismatch: pulse `err_o`, drop the partial configuration, go to IDLE. The next beat is treated as a first frame (resynchronisation).
  - DRAIN: `frame_ready_o`=1. Consumes `frame_length`-1 beats without storing them, then goes to IDLE. No further `err_o` pulses.
  - OUTPUT: `frame_ready_o`=0 and `cfg_valid_o`=1. `cfg_hdr_o` and `cfg_payload_o` stay stable until `cfg_ready_i`; after that handshake → IDLE.
- `idx_q` is 4 bits wide. All comparisons are unsigned and use the 4-bit width, so no wrap can occur (`frame_length` ≤ 15).

## Timing
- Reset values: `frame_ready_o`=0 during reset and 1 in the first cycle after release (IDLE). `cfg_valid_o`=0, `err_o`=0, header and payload registers all 0, `idx_q`=0, state IDLE.
- `frame_ready_o` is a function of state only. It never depends combinationally on `frame_valid_i`.
- Latency: `cfg_valid_o` rises in the cycle after the last frame handshake. A one-frame configuration goes from the handshake in cycle t to `cfg_valid_o` in cycle t+1.
- Back-to-back: the earliest next first-frame handshake is the cycle after the `cfg_valid_o`/`cfg_ready_i` handshake. Throughput for an N-frame configuration is therefore one per N+1 cycles.
- `err_o` is registered. It is high in the cycle after the offending handshake, for exactly one cycle.
- Reset asserted mid-COLLECT, mid-DRAIN or mid-OUTPUT: the next clock edge returns everything to reset values and discards the partial or pending configuration.

## Structure
- Add to `xdma_pkg`:
  - `xdma_inter_cluster_cont_t` (`remaining_payload_t`, `frame_length_t frame_idx`, `logic dma_type`).
  - `xdma_cfg_header_t`.
  - state enum `xdma_deframer_state_e` (IDLE, COLLECT, DRAIN, OUTPUT).
- No sub-module. The payload store is a slot array indexed by `idx_q`, inline.

## Test plan
- Single frame, `frame_length`=1, `dma_id`=3, `reader_addr`=0x1000, `writer_addr`=0x2000, `cfg_ready_i`=1 → `cfg_valid_o` the next cycle with those fields. Slots 1..3 are zero.
- Three frames with idx 1 and 2 and payload patterns A/B/C, one idle cycle inserted between the valid beats → `cfg_payload_o` = {0, C, B, A}, valid one cycle after the third handshake.
- `cfg_ready_i` held low for 5 cycles → `frame_ready_o`=0 and the outputs stay stable throughout. The next first frame is accepted the cycle after the handshake.
- Second frame carries idx 2 instead of 1 → `err_o` pulses once, no `cfg_valid_o`, and the following beat is parsed as a new first frame.
- `frame_length`=0 → one beat consumed, `err_o` pulses. `frame_length`=6 with `MaxFrames`=4 → 6 beats consumed, a single `err_o` pulse, no `cfg_valid_o`.
- Reset asserted after 2 of 4 frames, then a fresh one-frame configuration → only the fresh configuration is output.
